fifo_stream_reader: RTL

// Drains a standard-mode (non-FWFT) synchronous FIFO and presents its words as a valid/ready stream.

---
 rtl/fifo_stream_reader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Drains a standard-mode synchronous FIFO into a valid/ready stream through a small
// prefetch buffer that absorbs the FIFO read latency, with a word counter and sticky error flags.
module fifo_stream_reader #(
  parameter int unsigned G_DATAWIDTH  = 16,
  parameter int unsigned G_RD_LATENCY = 1,
  parameter int unsigned G_CNTWIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic [G_DATAWIDTH-1:0] fifo_dout,
  input  logic                   fifo_empty,
  input  logic                   fifo_rd_rst_busy,
  input  logic                   fifo_overflow,
  input  logic                   fifo_underflow,
  output logic                   fifo_rd_en,
  output logic [G_DATAWIDTH-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  input  logic                   cnt_clr,
  output logic [G_CNTWIDTH-1:0]  word_count,
  output logic                   err_overflow,
  output logic                   err_underflow
);

  localparam int unsigned Depth = G_RD_LATENCY + 1;
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam logic [CntW:0]   DepthC  = (CntW + 1)'(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [G_DATAWIDTH-1:0] buf_q [Depth];
  logic [G_DATAWIDTH-1:0] buf_d [Depth];
  logic [PtrW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]        buf_cnt_q, buf_cnt_d;
  logic [G_RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic [G_CNTWIDTH-1:0]  word_count_q, word_count_d;
  logic                   err_overflow_q, err_overflow_d;
  logic                   err_underflow_q, err_underflow_d;
  logic [CntW:0]          inflight;
  logic                   pop, capture;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign m_valid       = (buf_cnt_q != '0);
  assign m_data        = buf_q[head_q];
  assign word_count    = word_count_q;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;
  assign pop           = m_valid & m_ready;
  assign capture       = rd_pipe_q[G_RD_LATENCY-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(G_RD_LATENCY); i++) begin
      inflight = inflight + (CntW + 1)'(rd_pipe_q[i]);
    end
  end

  // Credit check: buf_cnt + inflight - pop < Depth, rearranged to avoid underflow.
  assign fifo_rd_en = !srst && !fifo_empty && !fifo_rd_rst_busy &&
                      (({1'b0, buf_cnt_q} + inflight) < (DepthC + (CntW + 1)'(pop)));

  always_comb begin
    rd_pipe_d    = '0;
    rd_pipe_d[0] = fifo_rd_en;
    for (int i = 1; i < int'(G_RD_LATENCY); i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end

    buf_d     = buf_q;
    head_d    = head_q;
    tail_d    = tail_q;
    buf_cnt_d = buf_cnt_q;
    if (capture) begin
      buf_d[tail_q] = fifo_dout;
      tail_d        = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d = ptr_inc(head_q);
    end
    case ({capture, pop})
      2'b10:   buf_cnt_d = buf_cnt_q + CntW'(1);
      2'b01:   buf_cnt_d = buf_cnt_q - CntW'(1);
      default: buf_cnt_d = buf_cnt_q;
    endcase

    if (cnt_clr) begin
      word_count_d = '0;
    end else if (pop) begin
      word_count_d = word_count_q + G_CNTWIDTH'(1);
    end else begin
      word_count_d = word_count_q;
    end

    err_overflow_d  = err_overflow_q | fifo_overflow;
    err_underflow_d = err_underflow_q | fifo_underflow | (fifo_rd_en & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        buf_q[i] <= '0;
      end
      head_q          <= '0;
      tail_q          <= '0;
      buf_cnt_q       <= '0;
      rd_pipe_q       <= '0;
      word_count_q    <= '0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      buf_q           <= buf_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      buf_cnt_q       <= buf_cnt_d;
      rd_pipe_q       <= rd_pipe_d;
      word_count_q    <= word_count_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

endmodule
